// File: rtl/binary_counter.sv
// Free-running counter with binary (up/down), ring (one-hot) or Johnson coding, plus terminal-count flag.
// Latency: count and tc are both registered; tc is high in the same cycle count holds its terminal state.
// Backpressure: none; no enable or flow control, so the counter advances on every clk edge outside reset.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   n_rst - asynchronous active-low reset
//   count - current counter state (flop output)
//   tc    - terminal-count flag (flop output), one cycle per period
module binary_counter #(
    parameter int WIDTH = 4,   // 2..32
    parameter int MODE  = 0,   // 0 binary, 1 ring, 2 Johnson, other -> binary
    parameter int DOWN  = 0    // binary only: 1 counts down
) (
    input  logic             clk,
    input  logic             n_rst,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam bit IS_RING = (MODE == 1);
    localparam bit IS_JOHN = (MODE == 2);
    localparam bit IS_DOWN = !IS_RING && !IS_JOHN && (DOWN != 0);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-2:0] ONE_D    = (WIDTH-1)'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // Ring restarts from a single set LSB; binary and Johnson from zero.
    localparam logic [WIDTH-1:0] RST_VAL = IS_RING ? ONE : {WIDTH{1'b0}};

    // State held in the cycle before the sequence wraps.
    localparam logic [WIDTH-1:0] TERM = (IS_RING || IS_JOHN) ? MSB_ONLY :
                                        (IS_DOWN ? {WIDTH{1'b0}} : ALL_ONES);

    // Counting down starts on the terminal state, so tc is already high in reset.
    localparam logic TC_RST = (RST_VAL == TERM);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ring_ok;
    logic             john_ok;
    logic [WIDTH-2:0] john_diff;

    always_comb begin
        // Legal ring state: exactly one bit set.
        ring_ok   = (count_q != {WIDTH{1'b0}}) &&
                    ((count_q & (count_q - ONE)) == {WIDTH{1'b0}});
        // Legal Johnson state: a single block of ones anchored at one end,
        // i.e. at most one transition between neighbouring bits.
        john_diff = count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0];
        john_ok   = ((john_diff & (john_diff - ONE_D)) == {(WIDTH-1){1'b0}});

        count_d = count_q + ONE;
        if (IS_RING) begin
            count_d = ring_ok ? {count_q[WIDTH-2:0], count_q[WIDTH-1]} : RST_VAL;
        end else if (IS_JOHN) begin
            count_d = john_ok ? {count_q[WIDTH-2:0], ~count_q[WIDTH-1]} : RST_VAL;
        end else if (IS_DOWN) begin
            count_d = count_q - ONE;
        end

        // Decoding the next state keeps tc aligned with the registered count.
        tc_d = (count_d == TERM);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= RST_VAL;
            tc_q    <= TC_RST;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_binary_counter.sv
module tb_binary_counter;

    localparam int N = 6;
    // Configurations: width, mode, down
    localparam int CW [N] = '{4, 4, 4, 4, 5, 3};
    localparam int CM [N] = '{0, 0, 1, 2, 2, 3};
    localparam int CD [N] = '{0, 1, 0, 0, 0, 0};

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    logic [3:0] c0, c1, c2, c3;
    logic [4:0] c4;
    logic [2:0] c5;
    logic       t0, t1, t2, t3, t4, t5;

    binary_counter u_bin  (.clk(clk), .n_rst(n_rst), .count(c0), .tc(t0));
    binary_counter #(.DOWN(1)) u_dn (.clk(clk), .n_rst(n_rst), .count(c1), .tc(t1));
    binary_counter #(.MODE(1)) u_ring (.clk(clk), .n_rst(n_rst), .count(c2), .tc(t2));
    binary_counter #(.MODE(2)) u_john (.clk(clk), .n_rst(n_rst), .count(c3), .tc(t3));
    binary_counter #(.WIDTH(5), .MODE(2)) u_j5 (.clk(clk), .n_rst(n_rst), .count(c4), .tc(t4));
    binary_counter #(.WIDTH(3), .MODE(3)) u_m3 (.clk(clk), .n_rst(n_rst), .count(c5), .tc(t5));

    logic [31:0] cnt [N];
    logic        tcv [N];

    always_comb begin
        cnt[0] = 32'(c0); cnt[1] = 32'(c1); cnt[2] = 32'(c2);
        cnt[3] = 32'(c3); cnt[4] = 32'(c4); cnt[5] = 32'(c5);
        tcv[0] = t0; tcv[1] = t1; tcv[2] = t2;
        tcv[3] = t3; tcv[4] = t4; tcv[5] = t5;
    end

    // Edges counted since the last reset (or self-correction) per instance.
    int steps [N];
    int vectors     = 0;
    int miscompares = 0;

    // Reference: the n-th state after reset, from the sequence definitions.
    function automatic logic [31:0] model_count(int i, int n);
        int     w = CW[i];
        longint m = longint'(1) << w;
        int     k;
        if (CM[i] == 1) return 32'(longint'(1) << (n % w));
        if (CM[i] == 2) begin
            k = n % (2 * w);
            if (k <= w) return 32'((longint'(1) << k) - 1);
            return 32'((m - 1) ^ ((longint'(1) << (k - w)) - 1));
        end
        if (CD[i] != 0) return 32'((m - longint'(n % m)) % m);
        return 32'(longint'(n) % m);
    endfunction

    function automatic logic [31:0] model_term(int i);
        longint m = longint'(1) << CW[i];
        if (CM[i] == 1 || CM[i] == 2) return 32'(longint'(1) << (CW[i] - 1));
        if (CD[i] != 0) return 32'd0;
        return 32'(m - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_c;
        for (int i = 0; i < N; i++) begin
            exp_c = model_count(i, steps[i]);
            chk($sformatf("%s count[%0d]", tag, i), cnt[i], exp_c);
            chk($sformatf("%s tc[%0d]", tag, i), 32'(tcv[i]),
                (exp_c == model_term(i)) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic clear_steps();
        for (int i = 0; i < N; i++) steps[i] = 0;
    endtask

    // Advance one edge and check 1 ns later.
    task automatic tick(input string tag);
        logic r;
        @(posedge clk);
        r = n_rst;
        #1;
        if (r) for (int i = 0; i < N; i++) steps[i]++;
        check_all(tag);
    endtask

    initial begin
        int dly;
        // Reset asserted before any edge; outputs must follow at once.
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #1;
        clear_steps();
        check_all("rst_async");
        repeat (3) tick("rst_hold");

        // Release 2 ns after an edge; run past a full binary wrap.
        #1 n_rst = 1'b1;
        repeat (20) tick("run");

        // Default counter is now at 4; bring it to 7, then reset between edges.
        repeat (3) tick("pre_mid");
        chk("mid_at7", cnt[0], 32'd7);
        #2 n_rst = 1'b0;
        #1;
        clear_steps();
        check_all("mid_rst");
        repeat (2) tick("mid_hold");
        #1 n_rst = 1'b1;
        repeat (5) tick("resume");

        // Illegal states in ring and Johnson must fall back to the reset value.
        force u_ring.count_q = 4'b0011;
        force u_john.count_q = 4'b0101;
        #1;
        release u_ring.count_q;
        release u_john.count_q;
        #1;
        chk("forced_ring", cnt[2], 32'h3);
        chk("forced_john", cnt[3], 32'h5);
        steps[2] = -1;
        steps[3] = -1;
        tick("self_corr");
        repeat (10) tick("post_corr");

        // Random run lengths with random mid-cycle reset pulses.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                dly = int'($urandom_range(1, 7));
                #(dly) n_rst = 1'b0;
                #1;
                clear_steps();
                check_all("rnd_rst");
                repeat ($urandom_range(1, 3)) tick("rnd_hold");
                #1 n_rst = 1'b1;
            end else begin
                repeat ($urandom_range(1, 8)) tick("rnd_run");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
